// File: rtl/nbbpu_mem_sequencer.sv
// -----------------------------------------------------------------------------
// nbbpu_mem_sequencer
//
// Multi-cycle sequencer that shares one single-port unified RAM (instructions
// and data) between the NBBPU core and a host loader port.
//
// For every instruction it fetches the word at the core's PC, holds it on
// o_instruction, performs the load or store the core asks for, and then gives
// the core a single o_cpu_step pulse so the core's PC and registers commit
// exactly once per instruction. While halted the RAM belongs to the host.
//
// Ports
//   i_clock            system clock
//   i_reset            synchronous, active-low reset
//   i_run              1 = execute, 0 = halt at the next instruction boundary
//   i_cpu_pc           core program counter
//   i_cpu_address      core data address
//   i_cpu_write_data   core store data
//   i_cpu_write_enable current instruction is a store
//   i_cpu_mem_read     current instruction is a load
//   o_instruction      registered instruction word to the core
//   o_read_data        registered load data to the core
//   o_cpu_step         one-cycle clock enable for core state commit
//   o_ram_address      RAM address
//   o_ram_write_data   RAM write data
//   o_ram_write_enable RAM write strobe
//   i_ram_read_data    RAM read data, valid READ_LATENCY cycles after the
//                      address is presented and held
//   i_host_req         host access request
//   i_host_we          1 = host write, 0 = host read
//   i_host_addr        host address
//   i_host_wdata       host write data
//   o_host_ack         one-cycle completion pulse
//   o_host_rdata       host read result, valid with o_host_ack and held
//   o_halted           1 while in IDLE or HOST
//   o_state            current FSM state (debug visibility)
//
// Host handshake: the host raises i_host_req with i_host_we/i_host_addr/
// i_host_wdata stable and holds all of them until it sees o_host_ack high for
// one cycle; the access is complete in that cycle and o_host_rdata is valid.
// The host must drop i_host_req in the ack cycle, otherwise the following
// IDLE cycle starts a new access.
//
// READ_LATENCY legal range is 1..4.
// -----------------------------------------------------------------------------
module nbbpu_mem_sequencer #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_cpu_pc,
    input  logic [ADDR_WIDTH-1:0] i_cpu_address,
    input  logic [DATA_WIDTH-1:0] i_cpu_write_data,
    input  logic                  i_cpu_write_enable,
    input  logic                  i_cpu_mem_read,
    output logic [DATA_WIDTH-1:0] o_instruction,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_cpu_step,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_write_data,
    output logic                  o_ram_write_enable,
    input  logic [DATA_WIDTH-1:0] i_ram_read_data,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic                  o_host_ack,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_halted,
    output logic [2:0]            o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_LOAD  = 3'd3,
        S_STORE = 3'd4,
        S_STEP  = 3'd5,
        S_HOST  = 3'd6
    } state_t;

    // Down-counter start value: an access occupies READ_LATENCY+1 cycles,
    // ending on the cycle where the counter reads zero.
    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY);

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_instruction;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] r_host_rdata;
    logic                  r_cpu_step;
    logic                  r_ram_we;
    logic                  r_host_ack;
    logic                  r_host_we;
    logic                  r_halted;

    logic [ADDR_WIDTH-1:0] w_ram_address;
    logic [DATA_WIDTH-1:0] w_ram_write_data;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_instruction <= '0;
            r_read_data   <= '0;
            r_host_rdata  <= '0;
            r_cpu_step    <= 1'b0;
            r_ram_we      <= 1'b0;
            r_host_ack    <= 1'b0;
            r_host_we     <= 1'b0;
            r_halted      <= 1'b1;
        end else begin
            // Pulse outputs are asserted only by the transition that needs them.
            r_cpu_step <= 1'b0;
            r_ram_we   <= 1'b0;
            r_host_ack <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (i_host_req) begin
                        // Host wins over run; a write needs only one cycle.
                        r_state   <= S_HOST;
                        r_host_we <= i_host_we;
                        r_ram_we  <= i_host_we;
                        r_cnt     <= i_host_we ? 3'd0 : LAST_CNT;
                    end else if (i_run) begin
                        r_state  <= S_FETCH;
                        r_cnt    <= LAST_CNT;
                        r_halted <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (r_cnt == 3'd0) begin
                        r_instruction <= i_ram_read_data;
                        r_state       <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                S_EXEC: begin
                    // Store has priority if the core flags both.
                    if (i_cpu_write_enable) begin
                        r_state  <= S_STORE;
                        r_ram_we <= 1'b1;
                    end else if (i_cpu_mem_read) begin
                        r_state <= S_LOAD;
                        r_cnt   <= LAST_CNT;
                    end else begin
                        r_state    <= S_STEP;
                        r_cpu_step <= 1'b1;
                    end
                end

                S_STORE: begin
                    r_state    <= S_STEP;
                    r_cpu_step <= 1'b1;
                end

                S_LOAD: begin
                    if (r_cnt == 3'd0) begin
                        r_read_data <= i_ram_read_data;
                        r_state     <= S_STEP;
                        r_cpu_step  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                S_STEP: begin
                    if (i_run && !i_host_req) begin
                        r_state <= S_FETCH;
                        r_cnt   <= LAST_CNT;
                    end else begin
                        r_state  <= S_IDLE;
                        r_halted <= 1'b1;
                    end
                end

                S_HOST: begin
                    // r_host_ack high marks the ack cycle that closes the access.
                    if (r_host_ack) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 3'd0) begin
                        if (!r_host_we) begin
                            r_host_rdata <= i_ram_read_data;
                        end
                        r_host_ack <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    // The address/data path is a state-selected mux rather than a register:
    // the core's PC advances on the very edge that leaves STEP, so a register
    // loaded on that edge would capture the old PC for the next fetch.
    always_comb begin
        w_ram_address    = '0;
        w_ram_write_data = '0;
        unique case (r_state)
            S_FETCH: w_ram_address = i_cpu_pc;
            S_LOAD:  w_ram_address = i_cpu_address;
            S_STORE: begin
                w_ram_address    = i_cpu_address;
                w_ram_write_data = i_cpu_write_data;
            end
            S_HOST: begin
                w_ram_address    = i_host_addr;
                w_ram_write_data = i_host_wdata;
            end
            default: begin
                w_ram_address    = '0;
                w_ram_write_data = '0;
            end
        endcase
    end

    assign o_instruction      = r_instruction;
    assign o_read_data        = r_read_data;
    assign o_cpu_step         = r_cpu_step;
    assign o_ram_address      = w_ram_address;
    assign o_ram_write_data   = w_ram_write_data;
    assign o_ram_write_enable = r_ram_we;
    assign o_host_ack         = r_host_ack;
    assign o_host_rdata       = r_host_rdata;
    assign o_halted           = r_halted;
    assign o_state            = r_state;

endmodule

// File: tb/tb_nbbpu_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nbbpu_mem_sequencer
//
// Two sequencer instances share one clock: index 0 uses READ_LATENCY=1 and
// index 1 uses READ_LATENCY=3. Each has its own RAM model whose read data is
// the addressed word delayed by its latency. The bench plays the core and the
// host; every expected value below is a hand-derived constant.
// -----------------------------------------------------------------------------
module tb_nbbpu_mem_sequencer;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_STORE = 3'd4;
    localparam logic [2:0] ST_HOST  = 3'd6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n, run, cpu_we, cpu_rd, host_req, host_we;
    logic [1:0][15:0] cpu_pc, cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic [1:0][15:0] instr, rdata, ram_addr, ram_wdata, ram_rdata, host_rdata;
    logic [1:0]       cpu_step, ram_we, host_ack, halted;
    logic [1:0][2:0]  state;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0]      mem [0:255];
        logic [3:0][15:0] pipe;

        nbbpu_mem_sequencer #(
            .ADDR_WIDTH  (16),
            .DATA_WIDTH  (16),
            .READ_LATENCY(LAT)
        ) dut (
            .i_clock           (clk),
            .i_reset           (rst_n[g]),
            .i_run             (run[g]),
            .i_cpu_pc          (cpu_pc[g]),
            .i_cpu_address     (cpu_addr[g]),
            .i_cpu_write_data  (cpu_wdata[g]),
            .i_cpu_write_enable(cpu_we[g]),
            .i_cpu_mem_read    (cpu_rd[g]),
            .o_instruction     (instr[g]),
            .o_read_data       (rdata[g]),
            .o_cpu_step        (cpu_step[g]),
            .o_ram_address     (ram_addr[g]),
            .o_ram_write_data  (ram_wdata[g]),
            .o_ram_write_enable(ram_we[g]),
            .i_ram_read_data   (ram_rdata[g]),
            .i_host_req        (host_req[g]),
            .i_host_we         (host_we[g]),
            .i_host_addr       (host_addr[g]),
            .i_host_wdata      (host_wdata[g]),
            .o_host_ack        (host_ack[g]),
            .o_host_rdata      (host_rdata[g]),
            .o_halted          (halted[g]),
            .o_state           (state[g])
        );

        // RAM model: word at the current address appears LAT edges later.
        always @(posedge clk) begin
            if (ram_we[g]) mem[ram_addr[g][7:0]] <= ram_wdata[g];
            pipe <= {pipe[2:0], mem[ram_addr[g][7:0]]};
        end
        assign ram_rdata[g] = pipe[LAT-1];
    end

    // ---------------- event monitors ----------------
    int n_cmp = 0;
    int n_err = 0;
    int we_cnt[2]   = '{0, 0};
    int step_cnt[2] = '{0, 0};
    int ack_cnt[2]  = '{0, 0};
    int run_cyc[2]  = '{0, 0};
    logic [1:0][15:0] we_addr, we_data;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_we[k]) begin
                we_cnt[k]  <= we_cnt[k] + 1;
                we_addr[k] <= ram_addr[k];
                we_data[k] <= ram_wdata[k];
            end
            if (cpu_step[k]) step_cnt[k] <= step_cnt[k] + 1;
            if (host_ack[k]) ack_cnt[k]  <= ack_cnt[k] + 1;
            if (!halted[k])  run_cyc[k]  <= run_cyc[k] + 1;
        end
    end

    // Per-cycle trace of the last instruction run, index 1 = first FETCH cycle.
    logic [15:0] tr_addr  [32];
    logic [15:0] tr_instr [32];
    logic [15:0] tr_rdata [32];
    logic [2:0]  tr_state [32];
    logic        tr_step  [32];
    logic        tr_we    [32];

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_access(input int k, input logic we, input logic [15:0] a,
                               input logic [15:0] d, output logic [15:0] rd,
                               output int cyc);
        host_req[k] = 1'b1; host_we[k] = we; host_addr[k] = a; host_wdata[k] = d;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (!host_ack[k] && cyc < 30);
        rd = host_rdata[k];
        host_req[k] = 1'b0; host_we[k] = 1'b0;
        tick(1);
    endtask

    task automatic run_instr(input int k, input int drop_at, output int step_at);
        for (int i = 0; i < 32; i++) begin
            tr_addr[i] = 16'hDEAD; tr_instr[i] = 16'hDEAD; tr_rdata[i] = 16'hDEAD;
            tr_state[i] = 3'd7; tr_step[i] = 1'b0; tr_we[i] = 1'b0;
        end
        step_at = 0;
        run[k]  = 1'b1;
        for (int c = 1; c < 32; c++) begin
            tick(1);
            tr_addr[c]  = ram_addr[k];
            tr_instr[c] = instr[k];
            tr_rdata[c] = rdata[k];
            tr_state[c] = state[k];
            tr_step[c]  = cpu_step[k];
            tr_we[c]    = ram_we[k];
            if (c == drop_at) run[k] = 1'b0;
            if (cpu_step[k] && step_at == 0) step_at = c;
            if (step_at != 0 && c >= step_at + 2) break;
        end
        run[k] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 2'b00;
        tick(3);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (state[k] !== ST_IDLE) begin
                n_err++; $display("FAIL reset_state[%0d]: got %0d want %0d", k, state[k], ST_IDLE);
            end
            n_cmp++;
            if ({instr[k], rdata[k], host_rdata[k], ram_addr[k], ram_wdata[k]} !== 80'h0) begin
                n_err++; $display("FAIL reset_data[%0d]: got %h want 0", k,
                                  {instr[k], rdata[k], host_rdata[k], ram_addr[k], ram_wdata[k]});
            end
            n_cmp++;
            if ({cpu_step[k], ram_we[k], host_ack[k], halted[k]} !== 4'b0001) begin
                n_err++; $display("FAIL reset_ctrl[%0d]: got %b want 0001", k,
                                  {cpu_step[k], ram_we[k], host_ack[k], halted[k]});
            end
        end
        rst_n = 2'b11;
        tick(1);
    endtask

    task automatic test_host();
        logic [15:0] rd;
        int cyc, a0, s0, r0;
        // program download
        host_access(0, 1'b1, 16'h0000, 16'h1234, rd, cyc);
        host_access(1, 1'b1, 16'h0000, 16'h8123, rd, cyc);
        host_access(1, 1'b1, 16'h0041, 16'hCAFE, rd, cyc);
        for (int k = 0; k < 2; k++) begin
            a0 = ack_cnt[k]; s0 = step_cnt[k]; r0 = run_cyc[k];
            host_access(k, 1'b1, 16'h0010, 16'h5A5A, rd, cyc);
            n_cmp++;
            if (cyc !== 2) begin
                n_err++; $display("FAIL host_write_ack_cycle[%0d]: got %0d want 2", k, cyc);
            end
            host_access(k, 1'b0, 16'h0010, 16'h0000, rd, cyc);
            n_cmp++;
            if (rd !== 16'h5A5A) begin
                n_err++; $display("FAIL host_rdata[%0d]: got %h want 5a5a", k, rd);
            end
            n_cmp++;
            if (cyc !== ((k == 0) ? 3 : 5)) begin
                n_err++; $display("FAIL host_read_ack_cycle[%0d]: got %0d want %0d", k, cyc, (k == 0) ? 3 : 5);
            end
            tick(2);
            n_cmp++;
            if (ack_cnt[k] - a0 !== 2) begin
                n_err++; $display("FAIL host_ack_pulses[%0d]: got %0d want 2", k, ack_cnt[k] - a0);
            end
            n_cmp++;
            if ((step_cnt[k] - s0) + (run_cyc[k] - r0) !== 0) begin
                n_err++; $display("FAIL host_halted[%0d]: got %0d non-halted/step events want 0", k,
                                  (step_cnt[k] - s0) + (run_cyc[k] - r0));
            end
        end
    endtask

    task automatic test_nonmem();
        int s, w0;
        w0 = we_cnt[0];
        cpu_pc[0] = 16'h0000; cpu_we[0] = 1'b0; cpu_rd[0] = 1'b0;
        run_instr(0, 1, s);
        n_cmp++;
        if (s !== 4) begin
            n_err++; $display("FAIL nonmem_step_cycle: got %0d want 4", s);
        end
        n_cmp++;
        if ({tr_state[1], tr_state[2], tr_state[3]} !== {ST_FETCH, ST_FETCH, ST_EXEC}) begin
            n_err++; $display("FAIL nonmem_states: got %0d %0d %0d want 1 1 2", tr_state[1], tr_state[2], tr_state[3]);
        end
        n_cmp++;
        if ({tr_addr[1], tr_addr[2]} !== 32'h0) begin
            n_err++; $display("FAIL nonmem_fetch_addr: got %h %h want 0 0", tr_addr[1], tr_addr[2]);
        end
        n_cmp++;
        if (tr_instr[4] !== 16'h1234) begin
            n_err++; $display("FAIL nonmem_instr: got %h want 1234", tr_instr[4]);
        end
        n_cmp++;
        if ({tr_step[5], tr_state[5], halted[0]} !== {1'b0, ST_IDLE, 1'b1}) begin
            n_err++; $display("FAIL nonmem_after_step: got step=%b state=%0d halted=%b want 0 0 1",
                              tr_step[5], tr_state[5], halted[0]);
        end
        n_cmp++;
        if (we_cnt[0] - w0 !== 0) begin
            n_err++; $display("FAIL nonmem_no_write: got %0d writes want 0", we_cnt[0] - w0);
        end
    endtask

    task automatic test_store();
        logic [15:0] rd;
        int s, w0, cyc;
        w0 = we_cnt[0];
        cpu_pc[0] = 16'h0000; cpu_we[0] = 1'b1; cpu_addr[0] = 16'h0040; cpu_wdata[0] = 16'hBEEF;
        run_instr(0, 1, s);
        cpu_we[0] = 1'b0;
        n_cmp++;
        if (s !== 5) begin
            n_err++; $display("FAIL store_step_cycle: got %0d want 5", s);
        end
        n_cmp++;
        if ({tr_state[4], tr_we[4], tr_addr[4]} !== {ST_STORE, 1'b1, 16'h0040}) begin
            n_err++; $display("FAIL store_cycle: got state=%0d we=%b addr=%h want 4 1 0040",
                              tr_state[4], tr_we[4], tr_addr[4]);
        end
        n_cmp++;
        if ((we_cnt[0] - w0 !== 1) || we_addr[0] !== 16'h0040 || we_data[0] !== 16'hBEEF) begin
            n_err++; $display("FAIL store_strobe: got n=%0d addr=%h data=%h want 1 0040 beef",
                              we_cnt[0] - w0, we_addr[0], we_data[0]);
        end
        host_access(0, 1'b0, 16'h0040, 16'h0000, rd, cyc);
        n_cmp++;
        if (rd !== 16'hBEEF) begin
            n_err++; $display("FAIL store_ram_content: got %h want beef", rd);
        end
    endtask

    task automatic test_load_drop_run();
        int s, s0, w0, bad_i, bad_a;
        s0 = step_cnt[1]; w0 = we_cnt[1];
        cpu_pc[1] = 16'h0000; cpu_rd[1] = 1'b1; cpu_addr[1] = 16'h0041; cpu_we[1] = 1'b0;
        run_instr(1, 5, s);   // run dropped during EXEC
        cpu_rd[1] = 1'b0;
        n_cmp++;
        if (s !== 10) begin
            n_err++; $display("FAIL load_step_cycle: got %0d want 10", s);
        end
        n_cmp++;
        if ({tr_rdata[9], tr_rdata[10]} !== {16'h0000, 16'hCAFE}) begin
            n_err++; $display("FAIL load_read_data: got %h %h want 0000 cafe", tr_rdata[9], tr_rdata[10]);
        end
        bad_i = 0; bad_a = 0;
        for (int c = 5; c <= 10; c++) if (tr_instr[c] !== 16'h8123) bad_i++;
        for (int c = 6; c <= 9; c++)  if (tr_addr[c] !== 16'h0041) bad_a++;
        n_cmp++;
        if (bad_i !== 0) begin
            n_err++; $display("FAIL load_instr_stable: got %0d bad cycles want 0", bad_i);
        end
        n_cmp++;
        if (bad_a !== 0) begin
            n_err++; $display("FAIL load_addr_held: got %0d bad cycles want 0", bad_a);
        end
        tick(3);
        n_cmp++;
        if ({state[1], halted[1]} !== {ST_IDLE, 1'b1}) begin
            n_err++; $display("FAIL load_stop_idle: got state=%0d halted=%b want 0 1", state[1], halted[1]);
        end
        n_cmp++;
        if ((step_cnt[1] - s0 !== 1) || (we_cnt[1] - w0 !== 0)) begin
            n_err++; $display("FAIL load_step_once: got steps=%0d writes=%0d want 1 0",
                              step_cnt[1] - s0, we_cnt[1] - w0);
        end
    endtask

    task automatic test_host_priority();
        int cyc, nh, s0;
        s0 = step_cnt[0];
        cpu_we[0] = 1'b0; cpu_rd[0] = 1'b0;
        run[0] = 1'b1; host_req[0] = 1'b1; host_we[0] = 1'b0; host_addr[0] = 16'h0040;
        cyc = 0; nh = 0;
        do begin
            tick(1);
            cyc++;
            if (!halted[0]) nh++;
        end while (!host_ack[0] && cyc < 30);
        n_cmp++;
        if ({cyc, nh, state[0]} !== {32'd3, 32'd0, ST_HOST}) begin
            n_err++; $display("FAIL prio_host_first: got ack_cycle=%0d run_cycles=%0d state=%0d want 3 0 6",
                              cyc, nh, state[0]);
        end
        n_cmp++;
        if (host_rdata[0] !== 16'hBEEF) begin
            n_err++; $display("FAIL prio_host_rdata: got %h want beef", host_rdata[0]);
        end
        host_req[0] = 1'b0;
        tick(1);
        n_cmp++;
        if ({state[0], halted[0]} !== {ST_IDLE, 1'b1}) begin
            n_err++; $display("FAIL prio_idle_after_ack: got state=%0d halted=%b want 0 1", state[0], halted[0]);
        end
        tick(1);
        n_cmp++;
        if ({state[0], halted[0]} !== {ST_FETCH, 1'b0}) begin
            n_err++; $display("FAIL prio_fetch_start: got state=%0d halted=%b want 1 0", state[0], halted[0]);
        end
        run[0] = 1'b0;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (!halted[0] && cyc < 30);
        tick(1);
        n_cmp++;
        if ((step_cnt[0] - s0 !== 1) || state[0] !== ST_IDLE) begin
            n_err++; $display("FAIL prio_one_instr: got steps=%0d state=%0d want 1 0", step_cnt[0] - s0, state[0]);
        end
    endtask

    task automatic test_reset_mid_store();
        int cyc, s0, w0;
        cpu_pc[0] = 16'h0000; cpu_we[0] = 1'b1; cpu_addr[0] = 16'h0042; cpu_wdata[0] = 16'h1111;
        s0 = step_cnt[0]; w0 = we_cnt[0];
        run[0] = 1'b1;
        cyc = 0;
        do begin
            tick(1);
            cyc++;
        end while (!ram_we[0] && cyc < 20);
        n_cmp++;
        if ({state[0], ram_we[0]} !== {ST_STORE, 1'b1}) begin
            n_err++; $display("FAIL rst_store_reached: got state=%0d we=%b want 4 1", state[0], ram_we[0]);
        end
        rst_n[0] = 1'b0; run[0] = 1'b0;
        tick(1);
        n_cmp++;
        if ({ram_we[0], cpu_step[0], host_ack[0], halted[0], state[0]} !== {4'b0001, ST_IDLE}) begin
            n_err++; $display("FAIL rst_ctrl: got we=%b step=%b ack=%b halted=%b state=%0d want 0 0 0 1 0",
                              ram_we[0], cpu_step[0], host_ack[0], halted[0], state[0]);
        end
        n_cmp++;
        if ({instr[0], rdata[0], host_rdata[0], ram_addr[0], ram_wdata[0]} !== 80'h0) begin
            n_err++; $display("FAIL rst_data: got %h want 0",
                              {instr[0], rdata[0], host_rdata[0], ram_addr[0], ram_wdata[0]});
        end
        tick(1);
        rst_n[0] = 1'b1;
        cpu_we[0] = 1'b0;
        tick(3);
        n_cmp++;
        if ((step_cnt[0] - s0 !== 0) || (we_cnt[0] - w0 !== 1)) begin
            n_err++; $display("FAIL rst_no_step: got steps=%0d writes=%0d want 0 1",
                              step_cnt[0] - s0, we_cnt[0] - w0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 2'b00; run = '0; cpu_we = '0; cpu_rd = '0; host_req = '0; host_we = '0;
        cpu_pc = '0; cpu_addr = '0; cpu_wdata = '0; host_addr = '0; host_wdata = '0;
        test_reset();
        test_host();
        test_nonmem();
        test_store();
        test_load_drop_run();
        test_host_priority();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
